// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional sticky-grant packet lock is built when UART_TX_ARB_LOCK_EN is defined.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_start,
  output logic [DATA_W-1:0]          uart_data,
  input  logic                       uart_ready,
  input  logic                       uart_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                active_q, active_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W:0]       scan_sum;
  logic [DATA_W-1:0]   words [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; the first valid index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[scan_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_sum[ID_W-1:0];
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    // A locked holder that still has a word keeps the channel for its packet.
    if (req_lock[grant_id_q] && req_valid[grant_id_q]) begin
      win_found = 1'b1;
      win_id    = grant_id_q;
    end
`endif
  end

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    ready_d    = '0;
    active_d   = active_q;
    uart_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (uart_ready && win_found) begin
          data_d          = words[win_id];
          ready_d[win_id] = 1'b1;
          grant_id_d      = win_id;
          ptr_d           = win_id;
          active_d        = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // Held high until the UART reports busy: it only samples start on its baud tick.
        uart_start = 1'b1;
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy && uart_ready) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      data_q     <= '0;
      ready_q    <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
    end
  end

  assign req_ready    = ready_q;
  assign uart_data    = data_q;
  assign grant_id     = grant_id_q;
  assign grant_active = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester loads push expected
// grants; a negedge monitor pops and compares on every accept pulse.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 9;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_start, uart_ready, uart_busy, grant_active;
  logic [DATA_W-1:0]         uart_data;
  logic [ID_W-1:0]           grant_id;

  logic man_busy    = 1'b0;
  logic model_busy  = 1'b0;
  logic model_en    = 1'b0;
  logic ready_block = 1'b0;

  int sent  [NUM_REQ];
  int base  [NUM_REQ];
  int limit [NUM_REQ];

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  assign uart_busy  = model_en ? model_busy : man_busy;
  assign uart_ready = !uart_busy && !ready_block;

  // Requester i's n-th word of the current load is i*32 + n.
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = sent[i] < limit[i];
      req_data[i*DATA_W +: DATA_W] = DATA_W'(i * 32 + sent[i] - base[i]);
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic                lock_test = 1'b0;
  logic [NUM_REQ-1:0]  req_lock;
  always_comb begin
    req_lock    = '0;
    req_lock[0] = lock_test && ((sent[0] - base[0]) < 3);
  end
`endif

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .req_ready    (req_ready),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_ready   (uart_ready),
    .uart_busy    (uart_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int id, input int d);
    exp_t x;
    x.id   = id;
    x.data = DATA_W'(d);
    exp_q.push_back(x);
  endtask

  task automatic load(input int i, input int n);
    base[i]  = sent[i];
    limit[i] = sent[i] + n;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < budget), 1);
  endtask

  // UART model: goes busy after seeing start for 2 cycles, stays busy 4 cycles.
  int hold = 0;
  int blen = 0;
  always @(negedge clk) begin
    if (!model_en) begin
      model_busy = 1'b0;
      hold       = 0;
      blen       = 0;
    end else if (!model_busy) begin
      if (uart_start) begin
        hold++;
        if (hold >= 2) begin
          model_busy = 1'b1;
          hold       = 0;
          blen       = 0;
        end
      end
    end else begin
      blen++;
      if (blen >= 4) model_busy = 1'b0;
    end
  end

  // Monitor: every accept pulse is matched against the scoreboard head.
  logic [NUM_REQ-1:0] prev_ready = '0;
  always @(negedge clk) begin
    if (req_ready != '0) begin
      check("pulse_width", 32'(prev_ready), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_accept", 32'(req_ready), 0);
      end else begin
        e = exp_q.pop_front();
        check("ready_onehot", 32'(req_ready), 32'(1) << e.id);
        check("grant_id", 32'(grant_id), e.id);
        check("uart_data", 32'(uart_data), 32'(e.data));
        check("start_on_accept", 32'(uart_start), 1);
        check("active_on_accept", 32'(grant_active), 1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) sent[i]++;
      end
    end
    prev_ready = req_ready;
  end

  initial begin
    int  n;
    logic flag;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_uart_start", 32'(uart_start), 0);
    check("rst_uart_data", 32'(uart_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_grant_active", 32'(grant_active), 0);

    // First grant from valid=1010, then a long start hold with busy driven by hand.
    @(negedge clk);
    rst = 1'b0;
    push(1, 32);
    push(3, 96);
    load(1, 1);
    load(3, 1);
    n = 0;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_accept_seen", 32'(req_ready != '0), 1);
    repeat (37) begin
      @(negedge clk);
      check("start_hold", 32'(uart_start), 1);
    end
    man_busy = 1'b1;
    @(negedge clk);
    check("start_drop", 32'(uart_start), 0);
    check("active_in_wait", 32'(grant_active), 1);
    repeat (5) begin
      @(negedge clk);
      check("no_early_accept", 32'(req_ready), 0);
    end
    man_busy = 1'b0;
    model_en = 1'b1;
    drain(300);

    // Rotation with all four requesters holding two words each.
    for (int k = 0; k < 2; k++) begin
      push(0, k);
      push(1, 32 + k);
      push(2, 64 + k);
      push(3, 96 + k);
    end
    for (int i = 0; i < NUM_REQ; i++) load(i, 2);
    drain(600);

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 0 locks for three words, then requester 2 gets its turn.
    lock_test = 1'b1;
    push(0, 0);
    push(0, 1);
    push(0, 2);
    push(2, 64);
    push(0, 3);
    load(0, 4);
    load(2, 1);
    drain(400);
    lock_test = 1'b0;
`endif

    // Back-pressure: no accept while the UART is not ready.
    ready_block = 1'b1;
    push(0, 0);
    load(0, 1);
    repeat (6) begin
      @(negedge clk);
      check("bp_no_ready", 32'(req_ready), 0);
      check("bp_idle", 32'(grant_active), 0);
    end
    ready_block = 1'b0;
    drain(100);

    // Reset during WAIT_DONE, then the pointer must start over at index 0.
    push(1, 32);
    load(1, 1);
    n    = 0;
    flag = 1'b0;
    while (!flag && n < 50) begin
      @(negedge clk);
      n++;
      flag = grant_active && !uart_start && exp_q.size() == 0;
    end
    check("reached_wait_done", 32'(flag), 1);
    model_en = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_uart_start", 32'(uart_start), 0);
    check("mid_rst_uart_data", 32'(uart_data), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    check("mid_rst_grant_active", 32'(grant_active), 0);
    push(1, 32);
    push(2, 64);
    load(1, 1);
    load(2, 1);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    model_en = 1'b1;
    drain(200);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
